// File: rtl/div_operand_stage_if.sv
// div_operand_stage_if
//   Groups the request, result and divider-side buses of div_operand_stage.
//   Signals:
//     in_valid/in_ready/in_a/in_b/in_signed  : request handshake and operands
//     out_valid/out_ready/out_quo/out_rem/out_div0 : result handshake and data
//     div_a/div_b                            : magnitudes to the external divider
//     div_quo/div_r                          : unsigned results from the divider
//   Modports:
//     slave  : the operand stage itself
//     master : requester, consumer and divider (the environment)
interface div_operand_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_a;
  logic [63:0] in_b;
  logic        in_signed;
  logic [63:0] div_a;
  logic [63:0] div_b;
  logic [63:0] div_quo;
  logic [63:0] div_r;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_quo;
  logic [63:0] out_rem;
  logic        out_div0;

  modport slave (
    input  in_valid, in_a, in_b, in_signed, div_quo, div_r, out_ready,
    output in_ready, div_a, div_b, out_valid, out_quo, out_rem, out_div0
  );

  modport master (
    output in_valid, in_a, in_b, in_signed, div_quo, div_r, out_ready,
    input  in_ready, div_a, div_b, out_valid, out_quo, out_rem, out_div0
  );
endinterface

// File: rtl/div_operand_stage.sv
// div_operand_stage
//   Two-stage wrapper around a combinational unsigned divider.
//   S1 registers operand magnitudes (driving div_a/div_b) plus sign and
//   divide-by-zero flags; S2 registers the sign-corrected quotient/remainder.
//   Ports:
//     clk    : clock, rising edge
//     rst_n  : asynchronous active-low reset
//     bus    : div_operand_stage_if.slave (request, divider and result buses)
module div_operand_stage (
  input logic                 clk,
  input logic                 rst_n,
  div_operand_stage_if.slave  bus
);

  // S1 state
  logic        s1_valid_q, s1_valid_d;
  logic [63:0] s1_a_q,     s1_a_d;
  logic [63:0] s1_b_q,     s1_b_d;
  logic [63:0] s1_raw_q,   s1_raw_d;
  logic        s1_negq_q,  s1_negq_d;
  logic        s1_negr_q,  s1_negr_d;
  logic        s1_div0_q,  s1_div0_d;

  // S2 state
  logic        s2_valid_q, s2_valid_d;
  logic [63:0] s2_quo_q,   s2_quo_d;
  logic [63:0] s2_rem_q,   s2_rem_d;
  logic        s2_div0_q,  s2_div0_d;

  logic s2_free;
  logic s1_adv;
  logic accept;

  // S2 can take a new result when empty or when its current one leaves now.
  assign s2_free      = !s2_valid_q || bus.out_ready;
  assign s1_adv       = s1_valid_q && s2_free;
  assign bus.in_ready = !s1_valid_q || s1_adv;
  assign accept       = bus.in_valid && bus.in_ready;

  assign bus.div_a     = s1_a_q;
  // A zero divisor is replaced by 1 so the divider never sees it.
  assign bus.div_b     = s1_div0_q ? 64'd1 : s1_b_q;
  assign bus.out_valid = s2_valid_q;
  assign bus.out_quo   = s2_quo_q;
  assign bus.out_rem   = s2_rem_q;
  assign bus.out_div0  = s2_div0_q;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_raw_d   = s1_raw_q;
    s1_negq_d  = s1_negq_q;
    s1_negr_d  = s1_negr_q;
    s1_div0_d  = s1_div0_q;
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_a_d     = (bus.in_signed && bus.in_a[63]) ? (64'd0 - bus.in_a) : bus.in_a;
      s1_b_d     = (bus.in_signed && bus.in_b[63]) ? (64'd0 - bus.in_b) : bus.in_b;
      s1_raw_d   = bus.in_a;
      s1_negq_d  = bus.in_signed & (bus.in_a[63] ^ bus.in_b[63]);
      s1_negr_d  = bus.in_signed & bus.in_a[63];
      s1_div0_d  = (bus.in_b == 64'd0);
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_quo_d   = s2_quo_q;
    s2_rem_d   = s2_rem_q;
    s2_div0_d  = s2_div0_q;
    if (s1_adv) begin
      s2_valid_d = 1'b1;
      s2_div0_d  = s1_div0_q;
      if (s1_div0_q) begin
        s2_quo_d = '1;
        s2_rem_d = s1_raw_q;
      end else begin
        s2_quo_d = s1_negq_q ? (64'd0 - bus.div_quo) : bus.div_quo;
        s2_rem_d = s1_negr_q ? (64'd0 - bus.div_r)   : bus.div_r;
      end
    end else if (bus.out_ready) begin
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_raw_q   <= '0;
      s1_negq_q  <= 1'b0;
      s1_negr_q  <= 1'b0;
      s1_div0_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_quo_q   <= '0;
      s2_rem_q   <= '0;
      s2_div0_q  <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_raw_q   <= s1_raw_d;
      s1_negq_q  <= s1_negq_d;
      s1_negr_q  <= s1_negr_d;
      s1_div0_q  <= s1_div0_d;
      s2_valid_q <= s2_valid_d;
      s2_quo_q   <= s2_quo_d;
      s2_rem_q   <= s2_rem_d;
      s2_div0_q  <= s2_div0_d;
    end
  end

endmodule

// File: tb/tb_div_operand_stage.sv
module tb_div_operand_stage;

  logic clk;
  logic rst_n;

  div_operand_stage_if bus ();

  div_operand_stage u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference combinational unsigned divider.
  assign bus.div_quo = (bus.div_b == 64'd0) ? '1     : bus.div_a / bus.div_b;
  assign bus.div_r   = (bus.div_b == 64'd0) ? bus.div_a : bus.div_a % bus.div_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] quo;
    logic [63:0] rem;
    logic        div0;
  } exp_t;

  exp_t exp_q[$];
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Result monitor: every transfer is compared against the next expected entry.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_out_valid", {63'd0, bus.out_valid}, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_quo",  bus.out_quo, e.quo);
        check("out_rem",  bus.out_rem, e.rem);
        check("out_div0", {63'd0, bus.out_div0}, {63'd0, e.div0});
      end
    end
  end

  // Present a request (call just after a rising edge); returns #1 after the
  // accepting edge with in_valid still high.
  task automatic send(input logic [63:0] a, input logic [63:0] b, input logic s,
                      input logic [63:0] eq, input logic [63:0] er, input logic ed);
    int unsigned n;
    n = 0;
    bus.in_valid  = 1'b1;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_signed = s;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.in_ready && n < 50);
    if (!bus.in_ready) begin
      check("accept_timeout", {63'd0, bus.in_ready}, 64'd1);
    end else begin
      exp_q.push_back('{quo: eq, rem: er, div0: ed});
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("drain_remaining", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_signed = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rst_out_quo",   bus.out_quo, 64'd0);
    check("rst_out_rem",   bus.out_rem, 64'd0);
    check("rst_div_a",     bus.div_a, 64'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);

    // Back-to-back 8/2, 9/2 with latency checks.
    send(64'd8, 64'd2, 1'b0, 64'd4, 64'd0, 1'b0);
    check("lat_not_yet", {63'd0, bus.out_valid}, 64'd0);
    check("div_a_8", bus.div_a, 64'd8);
    check("div_b_2", bus.div_b, 64'd2);
    send(64'd9, 64'd2, 1'b0, 64'd4, 64'd1, 1'b0);
    idle();
    check("lat_first_valid", {63'd0, bus.out_valid}, 64'd1);
    check("lat_first_quo",   bus.out_quo, 64'd4);
    @(posedge clk); #1;
    check("lat_second_valid", {63'd0, bus.out_valid}, 64'd1);
    check("lat_second_rem",   bus.out_rem, 64'd1);
    @(posedge clk); #1;
    check("lat_empty", {63'd0, bus.out_valid}, 64'd0);

    // Divide-by-zero: divider must see 1.
    send(64'd123, 64'd0, 1'b0, ONES, 64'd123, 1'b1);
    idle();
    check("div0_div_b", bus.div_b, 64'd1);
    drain();

    // Full-throughput stream of mixed cases.
    send(64'd42398284, 64'd54389, 1'b0, 64'd779, 64'd29253, 1'b0);
    send(64'd34224, 64'd789799, 1'b0, 64'd0, 64'd34224, 1'b0);
    send(-64'sd9, 64'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, ONES, 1'b0);
    send(64'd9, -64'sd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'd1, 1'b0);
    send(64'd123, 64'd0, 1'b1, ONES, 64'd123, 1'b1);
    send(MINV, ONES, 1'b1, MINV, 64'd0, 1'b0);
    send(-64'sd7, -64'sd3, 1'b1, 64'd2, ONES, 1'b0);
    send(-64'sd5, 64'd0, 1'b1, ONES, 64'hFFFF_FFFF_FFFF_FFFB, 1'b1);
    send(ONES, 64'd2, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    idle();
    drain();

    // Back-pressure: 3 requests while the consumer stalls.
    bus.out_ready = 1'b0;
    fork
      begin
        send(64'd100, 64'd7, 1'b0, 64'd14, 64'd2, 1'b0);
        send(64'd50,  64'd5, 1'b0, 64'd10, 64'd0, 1'b0);
        send(64'd17,  64'd3, 1'b0, 64'd5,  64'd2, 1'b0);
        idle();
      end
      begin
        repeat (4) @(posedge clk);
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          check("stall_valid",    {63'd0, bus.out_valid}, 64'd1);
          check("stall_quo",      bus.out_quo, 64'd14);
          check("stall_rem",      bus.out_rem, 64'd2);
          check("stall_in_ready", {63'd0, bus.in_ready}, 64'd0);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // Asynchronous reset with two requests in flight.
    bus.out_ready = 1'b0;
    send(64'd20, 64'd3, 1'b0, 64'd6, 64'd2, 1'b0);
    send(64'd21, 64'd4, 1'b0, 64'd5, 64'd1, 1'b0);
    idle();
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("arst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("arst_out_quo",   bus.out_quo, 64'd0);
    check("arst_out_rem",   bus.out_rem, 64'd0);
    check("arst_out_div0",  {63'd0, bus.out_div0}, 64'd0);
    check("arst_div_a",     bus.div_a, 64'd0);
    check("arst_div_b",     bus.div_b, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_rst_valid",    {63'd0, bus.out_valid}, 64'd0);
      check("post_rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
